// File: rtl/menu_overlay.sv
// Menu layer for the VGA compositor: stacked items, cursor highlight, debounced buttons, select handshake.
// Optional cursor blink: define MENU_OVERLAY_CURSOR_BLINK_EN.
module menu_overlay #(
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned N_ITEMS      = 4,
  parameter int unsigned H_ORIGIN     = 64,
  parameter int unsigned V_ORIGIN     = 48,
  parameter int unsigned ITEM_W       = 256,
  parameter int unsigned ITEM_H       = 32,
  parameter int unsigned ITEM_GAP     = 8,
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter logic [7:0]  COL_BG       = 8'h00,
  parameter logic [7:0]  COL_ITEM     = 8'hFF,
  parameter logic [7:0]  COL_HL       = 8'hE0,
  parameter logic [7:0]  COL_BORDER   = 8'h1C,
  parameter int unsigned BLINK_FRAMES = 32,
  localparam int unsigned IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  input  logic             enable,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  input  logic             sel_ack,
  output logic [2:0]       red,
  output logic [2:0]       green,
  output logic [1:0]       blue,
  output logic             layer,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_index,
  output logic [IDX_W-1:0] cursor
);

  localparam int unsigned PX_W = CNT_W + 1;
  localparam int unsigned CW   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [PX_W-1:0] PX_L  = PX_W'(H_ORIGIN);
  localparam logic [PX_W-1:0] PX_R  = PX_W'(H_ORIGIN + ITEM_W - 1);
  localparam logic [PX_W-1:0] PY_T  = PX_W'(V_ORIGIN);
  localparam logic [PX_W-1:0] PY_B  = PX_W'(V_ORIGIN + N_ITEMS*ITEM_H + (N_ITEMS-1)*ITEM_GAP - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ITEMS - 1);

  if (N_ITEMS < 2 || N_ITEMS > 16 || BLINK_FRAMES < 1 || DEBOUNCE_CYC < 1) begin : g_bad_cfg
    $error("menu_overlay: parameter out of range");
  end

  typedef enum logic {S_IDLE, S_HOLD} sel_state_e;

  logic [2:0]    btn_raw, sync1_q, sync2_q, db_q, db_prev_q, press;
  logic [CW-1:0] cnt_q [3];
  logic          up_p, down_p, sel_p, frame_start, hl_on;

  assign btn_raw     = {btn_sel, btn_down, btn_up};
  assign press       = db_q & ~db_prev_q;
  assign up_p        = press[0];
  assign down_p      = press[1];
  assign sel_p       = press[2];
  assign frame_start = (hcount == '0) && (vcount == '0);

  // Debounced level only flips after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) begin
          cnt_q[i] <= '0;
          db_q[i]  <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  logic [IDX_W-1:0] cursor_d, cursor_q, cursor_disp_q;

  always_comb begin
    cursor_d = cursor_q;
    if (enable && up_p && !down_p)
      cursor_d = (cursor_q == '0) ? LAST : cursor_q - IDX_W'(1);
    else if (enable && down_p && !up_p)
      cursor_d = (cursor_q == LAST) ? '0 : cursor_q + IDX_W'(1);
  end

  sel_state_e       state_q, state_d;
  logic             sel_valid_d, sel_valid_q;
  logic [IDX_W-1:0] sel_index_d, sel_index_q;

  always_comb begin
    state_d     = state_q;
    sel_valid_d = sel_valid_q;
    sel_index_d = sel_index_q;
    unique case (state_q)
      S_IDLE: if (sel_p && enable) begin
        sel_index_d = cursor_q;
        sel_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: if (sel_ack) begin
        sel_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cursor_q      <= '0;
      cursor_disp_q <= '0;
      state_q       <= S_IDLE;
      sel_valid_q   <= 1'b0;
      sel_index_q   <= '0;
    end else begin
      cursor_q    <= cursor_d;
      state_q     <= state_d;
      sel_valid_q <= sel_valid_d;
      sel_index_q <= sel_index_d;
      if (frame_start) cursor_disp_q <= cursor_q;
    end
  end

  assign cursor    = cursor_q;
  assign sel_valid = sel_valid_q;
  assign sel_index = sel_index_q;

`ifdef MENU_OVERLAY_CURSOR_BLINK_EN
  localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FC_W-1:0] frame_q;
  logic            blink_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
      blink_q <= 1'b1;
    end else if (frame_start) begin
      if (frame_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_q <= '0;
        blink_q <= ~blink_q;
      end else begin
        frame_q <= frame_q + FC_W'(1);
      end
    end
  end
  assign hl_on = blink_q;
`else
  assign hl_on = 1'b1;
`endif

  // Stage 1: geometry decode at CNT_W+1 bits so far-right/bottom bounds never wrap.
  logic [PX_W-1:0]  x, y, top, bot;
  logic             in_panel_d, hit_d, edge_d;
  logic [IDX_W-1:0] item_d;

  always_comb begin
    x          = {1'b0, hcount};
    y          = {1'b0, vcount};
    top        = '0;
    bot        = '0;
    hit_d      = 1'b0;
    item_d     = '0;
    edge_d     = (x == PX_L) || (x == PX_R);
    in_panel_d = (x >= PX_L) && (x <= PX_R) && (y >= PY_T) && (y <= PY_B);
    for (int unsigned k = 0; k < N_ITEMS; k++) begin
      top = PX_W'(V_ORIGIN + k*(ITEM_H + ITEM_GAP));
      bot = PX_W'(V_ORIGIN + k*(ITEM_H + ITEM_GAP) + ITEM_H - 1);
      if (y >= top && y <= bot) begin
        hit_d  = 1'b1;
        item_d = IDX_W'(k);
        if (y == top || y == bot) edge_d = 1'b1;
      end
    end
  end

  logic             in_panel_q, hit_q, edge_q, en1_q;
  logic [IDX_W-1:0] item_q;
  logic [7:0]       rgb_d, rgb_q;
  logic             layer_d, layer_q;

  always_comb begin
    rgb_d   = '0;
    layer_d = 1'b0;
    if (in_panel_q && en1_q) begin
      layer_d = 1'b1;
      if (!hit_q)                                rgb_d = COL_BG;
      else if (edge_q)                           rgb_d = COL_BORDER;
      else if (item_q == cursor_disp_q && hl_on) rgb_d = COL_HL;
      else                                       rgb_d = COL_ITEM;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_panel_q <= 1'b0;
      hit_q      <= 1'b0;
      edge_q     <= 1'b0;
      en1_q      <= 1'b0;
      item_q     <= '0;
      rgb_q      <= '0;
      layer_q    <= 1'b0;
    end else begin
      in_panel_q <= in_panel_d;
      hit_q      <= hit_d;
      edge_q     <= edge_d;
      en1_q      <= enable;
      item_q     <= item_d;
      rgb_q      <= rgb_d;
      layer_q    <= layer_d;
    end
  end

  assign red   = rgb_q[7:5];
  assign green = rgb_q[4:2];
  assign blue  = rgb_q[1:0];
  assign layer = layer_q;

endmodule

// File: tb/tb_menu_overlay.sv
// Directed bench for menu_overlay with a scoreboard of expected results.
module tb_menu_overlay;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] hcount = '0, vcount = '0;
  logic        enable = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0, sel_ack = 1'b0;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        layer, sel_valid;
  logic [1:0]  sel_index, cursor;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clock = ~clock;

  menu_overlay #(.DEBOUNCE_CYC(4), .N_ITEMS(4)) dut (
    .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .enable(enable), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .sel_ack(sel_ack), .red(red), .green(green), .blue(blue), .layer(layer),
    .sel_valid(sel_valid), .sel_index(sel_index), .cursor(cursor)
  );

  task automatic push(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  // m = {sel, down, up}; hold for `hold` cycles then release for 10
  task automatic press(input logic [2:0] m, input int hold);
    @(negedge clock);
    {btn_sel, btn_down, btn_up} = m;
    repeat (hold) @(posedge clock);
    @(negedge clock);
    {btn_sel, btn_down, btn_up} = 3'b000;
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic pix(input string t, input int h, input int v, input logic [8:0] e);
    @(negedge clock);
    hcount = 12'(h);
    vcount = 12'(v);
    push(t, 32'(e));
    repeat (2) @(posedge clock);
    #1 pop_check(32'({layer, red, green, blue}));
  endtask

  task automatic ack_pulse();
    @(negedge clock);
    sel_ack = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    sel_ack = 1'b0;
  endtask

  localparam logic [2:0] UP = 3'b001, DN = 3'b010, SEL = 3'b100;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    push("rst_pix", 32'h0);        pop_check(32'({layer, red, green, blue}));
    push("rst_sel_valid", 32'h0);  pop_check(32'(sel_valid));
    push("rst_sel_index", 32'h0);  pop_check(32'(sel_index));
    push("rst_cursor", 32'h0);     pop_check(32'(cursor));

    enable = 1'b1;
    push("down_1", 1); press(DN, 10); pop_check(32'(cursor));
    push("down_2", 2); press(DN, 10); pop_check(32'(cursor));
    push("down_3", 3); press(DN, 10); pop_check(32'(cursor));
    push("down_wrap", 0); press(DN, 10); pop_check(32'(cursor));
    push("up_wrap", 3); press(UP, 10); pop_check(32'(cursor));
    push("up_glitch", 3); press(UP, 2); pop_check(32'(cursor));
    push("up_down_both", 3); press(UP | DN, 10); pop_check(32'(cursor));
    enable = 1'b0;
    push("down_disabled", 3); press(DN, 10); pop_check(32'(cursor));
    enable = 1'b1;

    push("up_to_2", 2); press(UP, 10); pop_check(32'(cursor));
    push("sel_valid_1", 1); push("sel_index_2", 2);
    press(SEL, 10);
    pop_check(32'(sel_valid)); pop_check(32'(sel_index));
    push("hold_down", 3); press(DN, 10); pop_check(32'(cursor));
    push("hold_sel_valid", 1); push("hold_sel_frozen", 2);
    press(SEL, 10);
    pop_check(32'(sel_valid)); pop_check(32'(sel_index));
    push("ack_clears", 0); ack_pulse(); pop_check(32'(sel_valid));
    push("idle_ack_noop", 0); ack_pulse(); pop_check(32'(sel_valid));
    push("resel_valid", 1); push("resel_index", 3);
    press(SEL, 10);
    pop_check(32'(sel_valid)); pop_check(32'(sel_index));
    ack_pulse();

    push("up_to_2b", 2); press(UP, 10); pop_check(32'(cursor));
    push("up_to_1", 1); press(UP, 10); pop_check(32'(cursor));

    // hcount/vcount sat at (0,0) so the display cursor is now 1
    pix("pix_hl",        100, 93,  9'h1E0);
    pix("pix_border_tl", 64,  88,  9'h11C);
    pix("pix_gap",       100, 82,  9'h100);
    pix("pix_outside",   10,  10,  9'h000);
    pix("pix_item0",     100, 60,  9'h1FF);
    pix("pix_right_col", 319, 60,  9'h11C);
    pix("pix_past_right",320, 60,  9'h000);
    pix("pix_last_row",  100, 199, 9'h11C);
    pix("pix_past_bot",  100, 200, 9'h000);

    @(negedge clock);
    hcount = 12'd100; vcount = 12'd60;
    repeat (3) @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    push("en_fall_1clk", 32'h1FF);
    @(posedge clock);
    #1 pop_check(32'({layer, red, green, blue}));
    push("en_fall_2clk", 32'h0);
    @(posedge clock);
    #1 pop_check(32'({layer, red, green, blue}));

    @(negedge clock);
    enable = 1'b1;
    hcount = 12'd100; vcount = 12'd200;
    push("mid_down", 2); press(DN, 10); pop_check(32'(cursor));
    pix("mid_item2_old", 100, 133, 9'h1FF);
    pix("mid_item1_old", 100, 93,  9'h1E0);
    @(negedge clock);
    hcount = '0; vcount = '0;
    @(posedge clock);
    pix("new_item2_hl",  100, 133, 9'h1E0);
    pix("new_item1",     100, 93,  9'h1FF);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/menu_overlay.md
Name: menu_overlay

Overview:
- Parametrised menu layer for the VGA compositor. Renders N_ITEMS stacked rectangular items, a border and a highlighted cursor item in RGB332.
- Debounced up/down/select buttons move the cursor. A captured selection is presented to the game/shader logic with a valid/ack handshake.
- Drives `layer` per pixel, so the compositor shows the shader output outside the panel.

Parameters:
- CNT_W, 12, width of hcount/vcount
- N_ITEMS, 4, number of menu items (2..16)
- H_ORIGIN, 64, left x of the panel
- V_ORIGIN, 48, top y of the panel
- ITEM_W, 256, item width in pixels
- ITEM_H, 32, item height in pixels
- ITEM_GAP, 8, vertical gap between items
- DEBOUNCE_CYC, 250000, stable cycles required before a button level is accepted
- COL_BG, 8'h00, panel background / gap colour {r[2:0],g[2:0],b[1:0]}
- COL_ITEM, 8'hFF, item fill colour
- COL_HL, 8'hE0, cursor item fill colour
- COL_BORDER, 8'h1C, item border colour (1-pixel outline)
- BLINK_FRAMES, 32, frames per blink half-period (optional feature only)

Ports:
- clock  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- hcount  in  CNT_W  current pixel x
- vcount  in  CNT_W  current pixel y
- enable  in  1  menu visible / active
- btn_up  in  1  raw button, async
- btn_down  in  1  raw button, async
- btn_sel  in  1  raw button, async
- sel_ack  in  1  consumer accepts selection
- red  out  3  pixel red
- green  out  3  pixel green
- blue  out  2  pixel blue
- layer  out  1  1 = compositor uses this block's pixel
- sel_valid  out  1  selection pending
- sel_index  out  max(1,$clog2(N_ITEMS))  selected item
- cursor  out  max(1,$clog2(N_ITEMS))  current cursor item

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0: red/green/blue=0, layer=0, sel_valid=0, sel_index=0, cursor=0, debouncers cleared to level 0, select FSM in IDLE.

Buttons:
- Each button passes through a 2-FF synchroniser, then a debounce counter.
- The debounced level updates only after the synchronised input has differed from it for DEBOUNCE_CYC consecutive cycles. Any bounce restarts the count.
- A press is a one-cycle pulse on a 0->1 transition of the debounced level.

Cursor:
- Presses are ignored while enable=0.
- up: cursor-1, and 0 wraps to N_ITEMS-1.
- down: cursor+1, and N_ITEMS-1 wraps to 0.
- up and down pulses in the same cycle: no change.
- The display copy of the cursor (cursor_disp) loads from cursor only on the cycle where hcount==0 and vcount==0. This prevents mid-frame tearing.

Select FSM:
- IDLE: on a sel pulse with enable=1, sel_index<=cursor and sel_valid<=1; go to HOLD.
- HOLD: sel_valid stays 1 and sel_index is frozen. Further sel pulses are ignored; up/down still move the cursor.
  - On sel_ack=1: sel_valid<=0; go to IDLE.
  - sel_ack in IDLE has no effect.
- A sel pulse and sel_ack in the same HOLD cycle: ack is taken and the new press is dropped.

Pixel pipeline, latency 2 clocks from hcount/vcount to red/green/blue/layer:
- Stage 1 registers:
  - in_panel: x in [H_ORIGIN, H_ORIGIN+ITEM_W) and y in [V_ORIGIN, V_ORIGIN+N_ITEMS*ITEM_H+(N_ITEMS-1)*ITEM_GAP).
  - hit and item_idx: y falls in band k = [V_ORIGIN+k*(ITEM_H+ITEM_GAP), +ITEM_H).
  - edge: first or last row/column of an item box.
- Stage 2 selects the colour:
  - not in_panel or enable=0: rgb=0, layer=0.
  - in_panel and not hit (gap): COL_BG, layer=1.
  - hit and edge: COL_BORDER.
  - hit, item_idx==cursor_disp: COL_HL.
  - otherwise: COL_ITEM. layer=1 for all hit pixels.
- Comparisons are unsigned at CNT_W+1 bits, so panel bounds exceeding 2^CNT_W do not wrap.
- enable falling mid-line: outputs go to 0 exactly 2 clocks later.

Optional Feature:
- Macro: MENU_OVERLAY_CURSOR_BLINK_EN.
- Defined:
  - A frame counter increments at hcount==0, vcount==0 and toggles a blink bit every BLINK_FRAMES frames. The blink bit resets to 1.
  - While the blink bit is 0, the cursor item draws COL_ITEM instead of COL_HL.
- Undefined: highlight is steady, and there is no frame counter or blink logic.

Test Plan (DEBOUNCE_CYC=4, N_ITEMS=4):
- Reset, then hold reset_n=1: red/green/blue/layer/sel_valid/cursor all 0 before any scan.
- btn_down held 10 cycles, 4 times -> cursor 1,2,3,0 (wraps). btn_up once from 0 -> cursor 3. A 2-cycle glitch on btn_up -> no change.
- btn_up and btn_down asserted together for 10 cycles -> cursor unchanged. Presses with enable=0 -> cursor unchanged.
- cursor=2, press sel -> sel_valid=1, sel_index=2. Then press down (cursor=3) and sel again -> sel_index stays 2. sel_ack 1 cycle -> sel_valid=0 next cycle.
- enable=1, cursor_disp=1, drive (hcount,vcount)=(100,48+40+5) -> 2 clocks later rgb={7,0,0} (8'hE0), layer=1. At (64,88) -> COL_BORDER. At (100,48+32+2) -> COL_BG, layer=1. At (10,10) -> rgb=0, layer=0.
- Change cursor mid-frame (vcount=200) -> highlight moves only after next (0,0). With MENU_OVERLAY_CURSOR_BLINK_EN, BLINK_FRAMES=2 -> cursor item alternates COL_HL/COL_ITEM every 2 frames.
